// File: rtl/dnport_arbiter_pkg.sv
// Shared types and defaults for the download-port arbiter: FSM state encoding,
// requester index assignments and default port geometry.
package dnport_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        ACK     = 2'd3
    } dn_state_e;

    localparam int REQ_IOCTL  = 0;
    localparam int REQ_LOADER = 1;
    localparam int REQ_SS     = 2;

    localparam int DN_ADDR_W = 24;
    localparam int DN_RD_LAT = 2;

endpackage

// File: rtl/dnport_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request found when searching
// upward from the slot after the previous winner, wrapping at NREQ.
module rr_picker #(
    parameter int NREQ  = 3,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] winner_o
);

    logic [IDX_W-1:0] idx_s;

    // Scan from farthest to nearest so the nearest set bit is the last one written
    always_comb begin
        valid_o  = 1'b0;
        winner_o = '0;
        idx_s    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx_s    = IDX_W'((int'(last_i) + k) % NREQ);
            valid_o  = valid_o | req_i[idx_s];
            winner_o = req_i[idx_s] ? idx_s : winner_o;
        end
    end

endmodule

// File: rtl/dnport_arbiter.sv
// Arbitrates several requesters onto one download port: round-robin with burst
// lock, one strobe per transaction, fixed-latency read capture, one-cycle grant.
module dnport_arbiter
    import dnport_arbiter_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int ADDR_W = DN_ADDR_W,
    parameter int RD_LAT = DN_RD_LAT
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic [NREQ-1:0]          rq_req,
    input  logic [NREQ-1:0]          rq_we,
    input  logic [NREQ-1:0]          rq_lock,
    input  logic [NREQ*ADDR_W-1:0]   rq_addr,
    input  logic [NREQ*8-1:0]        rq_wdata,
    output logic [NREQ-1:0]          rq_gnt,
    output logic [7:0]               rq_rdata,
    output logic                     dn_go,
    output logic                     dn_wr,
    output logic                     dn_rd,
    output logic [ADDR_W-1:0]        dn_addr,
    output logic [7:0]               dn_data,
    input  logic [7:0]               dn_din
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE_HOT_LSB = NREQ'(1'b1);

    dn_state_e        state_q;
    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] win_q;
    logic             we_q;
    logic [2:0]       cnt_q;
    logic [NREQ-1:0]  gnt_q;
    logic [7:0]       rdata_q;
    logic             wr_q;
    logic             rd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]       data_q;

    logic [NREQ-1:0]   elig_s;
    logic              pick_valid_s;
    logic [IDX_W-1:0]  pick_idx_s;
    logic [ADDR_W-1:0] pick_addr_s;
    logic [7:0]        pick_data_s;

    // A held lock narrows eligibility to the previous winner alone
    always_comb begin
        elig_s = rq_req;
        if (rq_lock[last_q]) begin
            elig_s = rq_req & (ONE_HOT_LSB << last_q);
        end else begin
            elig_s = rq_req;
        end
    end

    rr_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req_i    (elig_s),
        .last_i   (last_q),
        .valid_o  (pick_valid_s),
        .winner_o (pick_idx_s)
    );

    // Route the winning requester's address and write data
    always_comb begin
        pick_addr_s = '0;
        pick_data_s = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            pick_addr_s = (pick_idx_s == IDX_W'(i)) ? rq_addr[i*ADDR_W +: ADDR_W] : pick_addr_s;
            pick_data_s = (pick_idx_s == IDX_W'(i)) ? rq_wdata[i*8 +: 8] : pick_data_s;
        end
    end

    // Transaction FSM with registered strobes, grant and read data
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= IDX_W'(NREQ - 1);
            win_q   <= '0;
            we_q    <= 1'b0;
            cnt_q   <= 3'd0;
            gnt_q   <= '0;
            rdata_q <= 8'h00;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= 8'h00;
        end else begin
            gnt_q <= '0;
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_valid_s) begin
                        win_q   <= pick_idx_s;
                        last_q  <= pick_idx_s;
                        we_q    <= rq_we[pick_idx_s];
                        wr_q    <= rq_we[pick_idx_s];
                        rd_q    <= ~rq_we[pick_idx_s];
                        addr_q  <= pick_addr_s;
                        data_q  <= pick_data_s;
                        state_q <= ISSUE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ISSUE: begin
                    cnt_q <= 3'd0;
                    if (we_q) begin
                        gnt_q   <= ONE_HOT_LSB << win_q;
                        state_q <= ACK;
                    end else begin
                        state_q <= WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    // Last wait cycle is the one where dn_din becomes valid
                    if (cnt_q == 3'(RD_LAT - 1)) begin
                        rdata_q <= dn_din;
                        gnt_q   <= ONE_HOT_LSB << win_q;
                        state_q <= ACK;
                    end else begin
                        cnt_q   <= cnt_q + 3'd1;
                        state_q <= WAIT_RD;
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Session flag also covers the idle gaps inside a locked burst
    assign dn_go    = !reset && ((state_q != IDLE) || rq_lock[last_q]);
    assign rq_gnt   = gnt_q;
    assign rq_rdata = rdata_q;
    assign dn_wr    = wr_q;
    assign dn_rd    = rd_q;
    assign dn_addr  = addr_q;
    assign dn_data  = data_q;

endmodule
